// File: rtl/m_div_unit.sv
// ---------------------------------------------------------------------------
// m_div_unit
// Iterative restoring radix-2 integer divider for DIV / DIVU / REM / REMU.
// One quotient bit per cycle over 32 cycles, followed by one sign-fix cycle.
// Divide-by-zero and signed overflow are resolved at acceptance and answered
// on the next edge.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   req_valid   request present
//   req_ready   unit idle and able to accept (registered)
//   req_op      bit1: 1=remainder / 0=quotient, bit0: 1=unsigned / 0=signed
//   req_rs1     dividend
//   req_rs2     divisor
//   flush       synchronous abort; wins over acceptance and response handshake
//   resp_valid  resp_data holds a finished result (registered)
//   resp_ready  consumer takes the result
//   resp_data   quotient or remainder, 0 outside DONE (registered)
//   busy        unit is not idle (registered)
// ---------------------------------------------------------------------------
module m_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    input  logic            flush,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};

    state_t          state;
    logic [5:0]      cnt;

    // Operation context captured while idle; frozen once a request is taken.
    logic [1:0]      op_q;
    logic            sign1_q;
    logic            sign2_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvs_q;

    // Request decode
    logic            req_signed;
    logic            sign1;
    logic            sign2;
    logic [XLEN-1:0] mag1;
    logic [XLEN-1:0] mag2;
    logic            div_zero;
    logic            ovf;

    assign req_signed = ~req_op[0];
    assign sign1      = req_signed & req_rs1[XLEN-1];
    assign sign2      = req_signed & req_rs2[XLEN-1];
    assign mag1       = sign1 ? (~req_rs1 + 1'b1) : req_rs1;
    assign mag2       = sign2 ? (~req_rs2 + 1'b1) : req_rs2;
    assign div_zero   = (req_rs2 == '0);
    assign ovf        = req_signed && (req_rs1 == MIN_NEG) && (req_rs2 == ALL_ONE);

    // One restoring step: shift {rem, quo} left, trial-subtract the divisor.
    // The shifted remainder needs XLEN+1 bits; after a successful subtract the
    // difference is below the divisor, so its low XLEN bits are exact.
    logic [XLEN:0]   rem_sh;
    logic            take;
    logic [XLEN-1:0] rem_nxt;
    logic [XLEN-1:0] quo_nxt;

    assign rem_sh  = {rem_q, quo_q[XLEN-1]};
    assign take    = (rem_sh >= {1'b0, dvs_q});
    assign rem_nxt = take ? (rem_sh[XLEN-1:0] - dvs_q) : rem_sh[XLEN-1:0];
    assign quo_nxt = {quo_q[XLEN-2:0], take};

    // Sign correction: quotient negative when signs differ, remainder takes
    // the dividend's sign.
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;
    logic [XLEN-1:0] fix_res;

    assign q_fix   = (!op_q[0] && (sign1_q ^ sign2_q)) ? (~quo_q + 1'b1) : quo_q;
    assign r_fix   = (!op_q[0] && sign1_q) ? (~rem_q + 1'b1) : rem_q;
    assign fix_res = op_q[1] ? r_fix : q_fix;

    // Datapath: loads continuously while idle, iterates in CALC.
    always_ff @(posedge clk) begin
        if (state == S_IDLE) begin
            op_q    <= req_op;
            sign1_q <= sign1;
            sign2_q <= sign2;
            rem_q   <= '0;
            quo_q   <= mag1;
            dvs_q   <= mag2;
        end else if (state == S_CALC) begin
            rem_q   <= rem_nxt;
            quo_q   <= quo_nxt;
        end
    end

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
        end else if (flush) begin
            state      <= S_IDLE;
            cnt        <= '0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        cnt       <= '0;
                        if (div_zero) begin
                            state      <= S_DONE;
                            resp_valid <= 1'b1;
                            resp_data  <= req_op[1] ? req_rs1 : ALL_ONE;
                        end else if (ovf) begin
                            state      <= S_DONE;
                            resp_valid <= 1'b1;
                            resp_data  <= req_op[1] ? '0 : MIN_NEG;
                        end else begin
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    cnt        <= '0;
                    resp_data  <= fix_res;
                    resp_valid <= 1'b1;
                    state      <= S_DONE;
                end
                S_DONE: begin
                    if (resp_ready) begin
                        state      <= S_IDLE;
                        req_ready  <= 1'b1;
                        busy       <= 1'b0;
                        resp_valid <= 1'b0;
                        resp_data  <= '0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_div_unit.sv
module tb_m_div_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    m_div_unit #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain 64-bit arithmetic with RISC-V divide-by-zero rule.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, q, r;
        if (op[0]) begin
            sa = longint'({32'h0, a});
            sb = longint'({32'h0, b});
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end
        if (b == 32'h0) begin
            q = -1;
            r = sa;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
        return op[1] ? r[31:0] : q[31:0];
    endfunction

    function automatic int model_lat(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
        if (b == 32'h0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue a request at posedge+1, count edges (acceptance edge = 1) until
    // resp_valid, check latency and data, then complete the handshake.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_data, input int exp_lat);
        int n;
        check({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_rs1   = a;
        req_rs2   = b;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 1;
        while (!resp_valid && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_lat"}, n, exp_lat);
        check({tag, "_data"}, resp_data, exp_data);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check({tag, "_vld_clr"}, {31'b0, resp_valid}, 32'd0);
        check({tag, "_data_clr"}, resp_data, 32'd0);
    endtask

    task automatic expect_no_resp(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (resp_valid) seen = 1'b1;
        end
        check(tag, {31'b0, seen}, 32'd0);
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a, b, held;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_op     = 2'b00;
        req_rs1    = '0;
        req_rs2    = '0;
        flush      = 1'b0;
        resp_ready = 1'b0;

        // Reset state before any clock edge
        #1;
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_vld", {31'b0, resp_valid}, 32'd0);
        check("rst_data", resp_data, 32'd0);
        #12 rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors
        run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        run_op("divu", 2'b01, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 34);
        run_op("remu", 2'b11, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, 34);
        run_op("div_z", 2'b00, 32'h1234, 32'h0, 32'hFFFF_FFFF, 1);
        run_op("rem_z", 2'b10, 32'h1234, 32'h0, 32'h0000_1234, 1);
        run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
        run_op("divu_big", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 34);

        // Randomized against the reference model
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'h0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            if (i == 5) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; op = 2'b00; end
            run_op("rand", op, a, b, model(op, a, b), model_lat(op, a, b));
        end

        // Backpressure: result held 5 cycles, next request waits for handshake
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_rs1   = 32'd100;
        req_rs2   = 32'hFFFF_FFF9;
        @(posedge clk); #1;
        for (int i = 0; i < 40 && !resp_valid; i++) begin
            @(posedge clk); #1;
        end
        held    = resp_data;
        check("bp_data", held, model(2'b00, 32'd100, 32'hFFFF_FFF9));
        req_op  = 2'b11;
        req_rs1 = 32'd1000;
        req_rs2 = 32'd7;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_vld_hold", {31'b0, resp_valid}, 32'd1);
            check("bp_data_hold", resp_data, held);
            check("bp_no_accept", {31'b0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("bp_hs_vld", {31'b0, resp_valid}, 32'd0);
        check("bp_hs_busy", {31'b0, busy}, 32'd0);
        check("bp_hs_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("bp_accept", {31'b0, busy}, 32'd1);
        for (int i = 0; i < 40 && !resp_valid; i++) begin
            @(posedge clk); #1;
        end
        check("bp_second", resp_data, model(2'b11, 32'd1000, 32'd7));
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;

        // Flush at CALC cycle 10
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_rs1   = 32'd12345;
        req_rs2   = 32'd17;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("fl_busy", {31'b0, busy}, 32'd0);
        check("fl_ready", {31'b0, req_ready}, 32'd1);
        expect_no_resp("fl_no_resp", 40);
        run_op("fl_after", 2'b00, 32'd12345, 32'd17, model(2'b00, 32'd12345, 32'd17), 34);

        // Flush beats acceptance in IDLE
        req_valid = 1'b1;
        flush     = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        flush     = 1'b0;
        check("fl_vs_accept", {31'b0, busy}, 32'd0);

        // Flush beats handshake in DONE
        req_valid = 1'b1;
        req_op    = 2'b10;
        req_rs1   = 32'h55;
        req_rs2   = 32'h0;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        check("fl_done_vld", {31'b0, resp_valid}, 32'd1);
        resp_ready = 1'b1;
        flush      = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        flush      = 1'b0;
        check("fl_done_clr", resp_data, 32'd0);
        check("fl_done_ready", {31'b0, req_ready}, 32'd1);

        // Asynchronous reset mid-CALC
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_rs1   = 32'hDEAD_BEEF;
        req_rs2   = 32'd3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("ar_busy", {31'b0, busy}, 32'd0);
        check("ar_ready", {31'b0, req_ready}, 32'd1);
        check("ar_vld", {31'b0, resp_valid}, 32'd0);
        #1 rst = 1'b0;
        expect_no_resp("ar_no_resp", 40);
        run_op("ar_after", 2'b01, 32'hDEAD_BEEF, 32'd3, model(2'b01, 32'hDEAD_BEEF, 32'd3), 34);

        // Asynchronous reset in DONE
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_rs1   = 32'd9;
        req_rs2   = 32'd0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("ard_vld", {31'b0, resp_valid}, 32'd0);
        check("ard_data", resp_data, 32'd0);
        #1 rst = 1'b0;
        expect_no_resp("ard_no_resp", 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/m_div_unit.md
M_DIV_UNIT -- requirements
Module: m_div_unit

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 req_valid  input  1  issuing stage presents a divide request.
REQ-005 req_ready  output  1  unit can accept a request.
REQ-006 req_op  input  2  bit1: 1 = remainder, 0 = quotient; bit0: 1 = unsigned, 0 = signed (DIV=00, DIVU=01, REM=10, REMU=11).
REQ-007 req_rs1  input  XLEN  dividend.
REQ-008 req_rs2  input  XLEN  divisor.
REQ-009 flush  input  1  synchronous abort of the operation in flight.
REQ-010 resp_valid  output  1  resp_data holds a finished result.
REQ-011 resp_ready  input  1  consumer accepts the result.
REQ-012 resp_data  output  XLEN  quotient or remainder per the latched req_op.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 The unit SHALL implement states IDLE, CALC, FIX and DONE.
REQ-015 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge with req_valid && req_ready.
REQ-016 On acceptance the unit SHALL latch req_op, the operand signs and the operand magnitudes (absolute values when signed; raw values when unsigned).
REQ-017 On acceptance with rs2 == 0, the unit SHALL go to DONE with quotient 0xFFFFFFFF and remainder = rs1 (unmodified).
REQ-018 On acceptance of a signed op with rs1 == 0x80000000 and rs2 == 0xFFFFFFFF, the unit SHALL go to DONE with quotient 0x80000000 and remainder 0.
REQ-019 Otherwise the unit SHALL go to CALC with a 6-bit iteration counter cleared to 0.
REQ-020 In CALC, each cycle SHALL perform one restoring radix-2 step: shift {rem, quo} left 1, subtract the divisor magnitude from the partial remainder, and set the quotient LSB to 1 and keep the difference when it is non-negative; otherwise restore.
REQ-021 After exactly 32 CALC cycles the unit SHALL go to FIX.
REQ-022 In FIX (one cycle), signed ops SHALL negate the quotient when the operand signs differ and SHALL give the remainder the sign of rs1; the result SHALL be registered and the unit SHALL go to DONE.
REQ-023 Normal-path latency SHALL be 34 rising edges from the acceptance edge to resp_valid high; special-case latency (REQ-017/018) SHALL be 1 edge.
REQ-024 In DONE, resp_valid SHALL be 1 and resp_data SHALL remain stable until the edge where resp_ready is 1; on that edge the unit SHALL return to IDLE.
REQ-025 A new request SHALL NOT be accepted in the cycle of the response handshake; earliest acceptance is the following cycle.
REQ-026 flush SHALL force IDLE on the next edge from any state, with no response produced; flush has priority over acceptance and over the response handshake.
REQ-027 Outside DONE, resp_data SHALL be 0.

Reset
REQ-028 While rst is high, the unit SHALL be in IDLE with resp_valid = 0, resp_data = 0, busy = 0, req_ready = 1 and the counter = 0, regardless of clk.
REQ-029 A reset asserted mid-CALC or in DONE SHALL discard the operation; no response SHALL appear after deassertion.

Verification
REQ-030 DIV: rs1 = 0xFFFFFFF9 (-7), rs2 = 2 -> after 34 edges resp_data = 0xFFFFFFFD (-3); REM of the same operands -> 0xFFFFFFFF (-1).
REQ-031 DIVU: rs1 = 0xFFFFFFFF, rs2 = 0x10 -> 0x0FFFFFFF; REMU -> 0x0000000F.
REQ-032 Divide by zero: DIV with rs1 = 0x1234 and rs2 = 0 -> resp_data = 0xFFFFFFFF one edge later; REM -> 0x00001234.
REQ-033 Overflow: DIV with rs1 = 0x80000000 and rs2 = 0xFFFFFFFF -> 0x80000000 one edge later; REM -> 0.
REQ-034 Backpressure: hold resp_ready = 0 for 5 cycles in DONE -> resp_valid and resp_data stay stable; with req_valid held high, the next request is accepted only on the cycle after the handshake.
REQ-035 Flush at CALC cycle 10, and separately an async rst pulse mid-CALC -> IDLE, no resp_valid pulse, and a subsequent request completes correctly.
